// File: rtl/adma_dm_src_sched_if.sv
// Requester and datamover-order signals for the source-side transaction scheduler.
interface adma_dm_src_sched_if #(
  parameter int DMA_CHN_NUM  = 4,
  parameter int MST_ID_W     = 5,
  parameter int ATX_LEN_W    = 8,
  parameter int ATX_NUM_OSTD = DMA_CHN_NUM
);
  localparam int CNT_W = $clog2(ATX_NUM_OSTD + 1);

  logic [DMA_CHN_NUM-1:0]           chn_req_vld;
  logic [DMA_CHN_NUM*ATX_LEN_W-1:0] chn_req_len;
  logic [DMA_CHN_NUM*MST_ID_W-1:0]  chn_id;
  logic [DMA_CHN_NUM-1:0]           chn_req_rdy;
  logic [DMA_CHN_NUM-1:0]           chn_busy;
  logic [DMA_CHN_NUM-1:0]           chn_done;
  logic [MST_ID_W-1:0]              atx_arid;
  logic [ATX_LEN_W-1:0]             atx_arlen;
  logic                             atx_vld;
  logic                             atx_rdy;
  logic                             atx_rdata_vld;
  logic                             atx_rdata_rdy;
  logic [CNT_W-1:0]                 ostd_cnt;
  logic                             beat_err;

  modport master (
    output chn_req_vld, chn_req_len, chn_id, atx_rdy, atx_rdata_vld, atx_rdata_rdy,
    input  chn_req_rdy, chn_busy, chn_done, atx_arid, atx_arlen, atx_vld, ostd_cnt, beat_err
  );

  modport slave (
    input  chn_req_vld, chn_req_len, chn_id, atx_rdy, atx_rdata_vld, atx_rdata_rdy,
    output chn_req_rdy, chn_busy, chn_done, atx_arid, atx_arlen, atx_vld, ostd_cnt, beat_err
  );
endinterface

// File: rtl/adma_dm_src_sched.sv
// Round-robin read-order scheduler: grants one channel at a time, issues (arid, arlen),
// and retires transactions in issue order by counting monitored data beats.
module adma_dm_src_sched_lane (
  input  logic clk,
  input  logic rst,
  input  logic set_i,
  input  logic clr_i,
  output logic busy_o,
  output logic done_o
);
  logic busy_q, done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (busy_q | set_i) & ~clr_i;
      done_q <= clr_i;
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
endmodule

module adma_dm_src_sched #(
  parameter int DMA_CHN_NUM  = 4,
  parameter int MST_ID_W     = 5,
  parameter int ATX_LEN_W    = 8,
  parameter int ATX_NUM_OSTD = DMA_CHN_NUM
) (
  input logic                aclk,
  input logic                areset,
  adma_dm_src_sched_if.slave bus
);
  localparam int CNT_W = $clog2(ATX_NUM_OSTD + 1);
  localparam int IDX_W = (DMA_CHN_NUM > 1) ? $clog2(DMA_CHN_NUM) : 1;
  localparam int PTR_W = (ATX_NUM_OSTD > 1) ? $clog2(ATX_NUM_OSTD) : 1;
  localparam logic [CNT_W-1:0] OSTD_MAX = CNT_W'(ATX_NUM_OSTD);

  typedef enum logic {IDLE, ISSUE} state_e;
  typedef struct packed {
    logic [IDX_W-1:0]     idx;
    logic [ATX_LEN_W-1:0] len;
  } ord_t;

  state_e               state_q, state_d;
  logic [IDX_W-1:0]     rr_q, rr_d, gnt_q, gnt_d, g;
  logic [MST_ID_W-1:0]  arid_q, arid_d;
  logic [ATX_LEN_W-1:0] arlen_q, arlen_d, beat_q, beat_d;
  logic [CNT_W-1:0]     ostd_q, ostd_d;
  logic [PTR_W-1:0]     wp_q, wp_d, rp_q, rp_d;
  logic                 err_q, err_d;
  ord_t                 fifo_q [ATX_NUM_OSTD];
  ord_t                 head;

  logic [DMA_CHN_NUM-1:0] busy, done, elig, req_rdy, set_busy, clr_busy;
  logic                   found, push, pop, beat, empty;
  int unsigned            c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (int'(p) == ATX_NUM_OSTD - 1) ? '0 : p + 1'b1;
  endfunction

  // Grant search and order FSM; eligibility uses registered busy bits only.
  always_comb begin
    elig    = bus.chn_req_vld & ~busy & {DMA_CHN_NUM{ostd_q < OSTD_MAX}};
    found   = 1'b0;
    g       = '0;
    c       = 0;
    for (int k = 0; k < DMA_CHN_NUM; k++) begin
      c = int'(rr_q) + k;
      if (c >= DMA_CHN_NUM) c = c - DMA_CHN_NUM;
      if (!found && elig[c]) begin
        found = 1'b1;
        g     = IDX_W'(c);
      end
    end
    state_d = state_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    arid_d  = arid_q;
    arlen_d = arlen_q;
    req_rdy = '0;
    push    = 1'b0;
    case (state_q)
      IDLE: if (found && !areset) begin
        req_rdy[g] = 1'b1;
        gnt_d      = g;
        arid_d     = bus.chn_id[int'(g)*MST_ID_W +: MST_ID_W];
        arlen_d    = bus.chn_req_len[int'(g)*ATX_LEN_W +: ATX_LEN_W];
        rr_d       = (int'(g) == DMA_CHN_NUM - 1) ? '0 : g + 1'b1;
        state_d    = ISSUE;
      end
      ISSUE: if (bus.atx_rdy) begin
        push    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Beat monitor: the head order retires on its (len+1)-th beat.
  always_comb begin
    head     = fifo_q[rp_q];
    empty    = (ostd_q == '0);
    beat     = bus.atx_rdata_vld & bus.atx_rdata_rdy;
    pop      = beat && !empty && (beat_q == head.len);
    beat_d   = beat_q;
    if (beat && !empty) beat_d = pop ? '0 : beat_q + 1'b1;
    err_d    = err_q | (beat & empty);
    ostd_d   = ostd_q + CNT_W'(push) - CNT_W'(pop);
    wp_d     = push ? ptr_inc(wp_q) : wp_q;
    rp_d     = pop ? ptr_inc(rp_q) : rp_q;
    set_busy = '0;
    clr_busy = '0;
    if (push) set_busy[gnt_q]   = 1'b1;
    if (pop)  clr_busy[head.idx] = 1'b1;
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gnt_q   <= '0;
      arid_q  <= '0;
      arlen_q <= '0;
      beat_q  <= '0;
      ostd_q  <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      arid_q  <= arid_d;
      arlen_q <= arlen_d;
      beat_q  <= beat_d;
      ostd_q  <= ostd_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      err_q   <= err_d;
      if (push) fifo_q[wp_q] <= '{idx: gnt_q, len: arlen_q};
    end
  end

  adma_dm_src_sched_lane u_lane [DMA_CHN_NUM-1:0] (
    .clk    (aclk),
    .rst    (areset),
    .set_i  (set_busy),
    .clr_i  (clr_busy),
    .busy_o (busy),
    .done_o (done)
  );

  assign bus.chn_req_rdy = req_rdy;
  assign bus.chn_busy    = busy;
  assign bus.chn_done    = done;
  assign bus.atx_vld     = (state_q == ISSUE);
  assign bus.atx_arid    = arid_q;
  assign bus.atx_arlen   = arlen_q;
  assign bus.ostd_cnt    = ostd_q;
  assign bus.beat_err    = err_q;
endmodule

// File: tb/tb_adma_dm_src_sched.sv
// Bench for adma_dm_src_sched: vector table, directed corner sequences, random run vs queue model.
module tb_adma_dm_src_sched;
  localparam int N = 4, IW = 5, LW = 8, OS = 2;
  localparam logic [N-1:0][IW-1:0] IDS = {5'd17, 5'd9, 5'd5, 5'd3};

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  logic [N-1:0]         r_vld;
  logic [N-1:0][LW-1:0] r_len;
  logic                 r_ardy, r_bv, r_br;

  adma_dm_src_sched_if #(.DMA_CHN_NUM(N), .MST_ID_W(IW), .ATX_LEN_W(LW), .ATX_NUM_OSTD(OS)) ifc ();
  adma_dm_src_sched #(.DMA_CHN_NUM(N), .MST_ID_W(IW), .ATX_LEN_W(LW), .ATX_NUM_OSTD(OS)) dut (
    .aclk(aclk), .areset(areset), .bus(ifc));

  assign ifc.chn_req_vld   = r_vld;
  assign ifc.chn_req_len   = r_len;
  assign ifc.chn_id        = IDS;
  assign ifc.atx_rdy       = r_ardy;
  assign ifc.atx_rdata_vld = r_bv;
  assign ifc.atx_rdata_rdy = r_br;

  // Reference model: pending order, in-order queue of outstanding {channel, len}, beat count.
  typedef struct { int idx; int len; } ord_t;
  ord_t     mq[$];
  bit [N-1:0] m_busy = '0, m_done = '0;
  bit       m_iss = 0, m_err = 0;
  int       m_g = 0, m_len = 0, m_rr = 0, m_beat = 0, m_pick = -1;
  int       compared = 0, mismatched = 0;
  int       gq[$];

  typedef struct {
    bit rst; bit [N-1:0] vld; bit [N-1:0][LW-1:0] len; bit ardy, beat;
    bit [N-1:0] e_rdy; bit e_vld; int e_id, e_len; bit [N-1:0] e_busy, e_done; int e_ostd; bit e_err;
  } vec_t;
  vec_t tv[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int pick();
    if (m_iss || areset || mq.size() >= OS) return -1;
    for (int k = 0; k < N; k++) begin
      int ch = (m_rr + k) % N;
      if (r_vld[ch] && !m_busy[ch]) return ch;
    end
    return -1;
  endfunction

  task automatic sample();
    logic [N-1:0] e_rdy;
    @(negedge aclk);
    m_pick = pick();
    e_rdy  = '0;
    if (m_pick >= 0) e_rdy[m_pick] = 1'b1;
    chk("req_rdy", 32'(ifc.chn_req_rdy), 32'(e_rdy));
    chk("atx_vld", 32'(ifc.atx_vld), 32'(m_iss));
    if (m_iss) begin
      chk("arid", 32'(ifc.atx_arid), 32'(IDS[m_g]));
      chk("arlen", 32'(ifc.atx_arlen), 32'(m_len));
    end
    chk("busy", 32'(ifc.chn_busy), 32'(m_busy));
    chk("done", 32'(ifc.chn_done), 32'(m_done));
    chk("ostd_cnt", 32'(ifc.ostd_cnt), 32'(mq.size()));
    chk("beat_err", 32'(ifc.beat_err), 32'(m_err));
    for (int k = 0; k < N; k++) if (ifc.chn_req_rdy[k] === 1'b1) gq.push_back(k);
  endtask

  task automatic advance();
    ord_t o;
    if (areset) begin
      mq.delete(); m_busy = '0; m_done = '0; m_iss = 0; m_rr = 0; m_beat = 0; m_err = 0;
    end else begin
      m_done = '0;
      if (r_bv && r_br) begin
        if (mq.size() == 0) m_err = 1;
        else if (m_beat == mq[0].len) begin
          m_done[mq[0].idx] = 1'b1;
          m_busy[mq[0].idx] = 1'b0;
          void'(mq.pop_front());
          m_beat = 0;
        end else m_beat++;
      end
      if (m_iss && r_ardy) begin
        o.idx = m_g; o.len = m_len;
        mq.push_back(o);
        m_busy[m_g] = 1'b1;
        m_iss = 0;
      end else if (m_pick >= 0) begin
        m_iss = 1; m_g = m_pick; m_len = int'(r_len[m_pick]); m_rr = (m_pick + 1) % N;
      end
    end
    @(posedge aclk); #1;
  endtask

  task automatic step();
    sample();
    advance();
  endtask

  task automatic idle_inputs();
    r_vld = '0; r_len = '0; r_ardy = 0; r_bv = 0; r_br = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    areset = 1; step(); areset = 0;
    gq.delete();
  endtask

  task automatic addv(input bit rst, input bit [N-1:0] vld, input int l1, l2, input bit ardy, beat,
                      input bit [N-1:0] er, input bit ev, input int eid, elen,
                      input bit [N-1:0] eb, ed, input int eo, input bit ee);
    vec_t v;
    v.rst = rst; v.vld = vld; v.len = '0; v.len[1] = LW'(l1); v.len[2] = LW'(l2);
    v.ardy = ardy; v.beat = beat; v.e_rdy = er; v.e_vld = ev; v.e_id = eid; v.e_len = elen;
    v.e_busy = eb; v.e_done = ed; v.e_ostd = eo; v.e_err = ee;
    tv.push_back(v);
  endtask

  initial begin
    #(10 * 50000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] acc;
    // ch1 len3 single request, then ch2 len0 under 5 cycles of backpressure
    addv(1, 4'b0000, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    addv(0, 4'b0010, 3, 0, 1, 0, 4'b0010, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    addv(0, 4'b0000, 3, 0, 1, 0, 4'b0000, 1, 5, 3, 4'b0000, 4'b0000, 0, 0);
    for (int i = 0; i < 4; i++)
      addv(0, 4'b0000, 0, 0, 1, 1, 4'b0000, 0, 0, 0, 4'b0010, 4'b0000, 1, 0);
    addv(0, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0010, 0, 0);
    addv(0, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    addv(0, 4'b0100, 0, 0, 0, 0, 4'b0100, 0, 0, 0, 4'b0000, 4'b0000, 0, 0);
    for (int i = 0; i < 5; i++)
      addv(0, 4'b0000, 0, 0, 0, 0, 4'b0000, 1, 9, 0, 4'b0000, 4'b0000, 0, 0);
    addv(0, 4'b0000, 0, 0, 1, 0, 4'b0000, 1, 9, 0, 4'b0000, 4'b0000, 0, 0);
    addv(0, 4'b0000, 0, 0, 1, 1, 4'b0000, 0, 0, 0, 4'b0100, 4'b0000, 1, 0);
    addv(0, 4'b0000, 0, 0, 1, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0100, 0, 0);

    idle_inputs();
    areset = 1;
    @(posedge aclk); #1;
    foreach (tv[i]) begin
      areset = tv[i].rst; r_vld = tv[i].vld; r_len = tv[i].len; r_ardy = tv[i].ardy;
      r_bv = tv[i].beat; r_br = tv[i].beat;
      sample();
      chk($sformatf("tv%0d_rdy", i), 32'(ifc.chn_req_rdy), 32'(tv[i].e_rdy));
      chk($sformatf("tv%0d_vld", i), 32'(ifc.atx_vld), 32'(tv[i].e_vld));
      if (tv[i].e_vld) begin
        chk($sformatf("tv%0d_arid", i), 32'(ifc.atx_arid), tv[i].e_id);
        chk($sformatf("tv%0d_arlen", i), 32'(ifc.atx_arlen), tv[i].e_len);
      end
      chk($sformatf("tv%0d_busy", i), 32'(ifc.chn_busy), 32'(tv[i].e_busy));
      chk($sformatf("tv%0d_done", i), 32'(ifc.chn_done), 32'(tv[i].e_done));
      chk($sformatf("tv%0d_ostd", i), 32'(ifc.ostd_cnt), tv[i].e_ostd);
      chk($sformatf("tv%0d_err", i), 32'(ifc.beat_err), 32'(tv[i].e_err));
      advance();
    end

    // Round robin with continuous requests and immediate retirement.
    do_reset();
    r_vld = '1; r_ardy = 1;
    for (int i = 0; i < 12; i++) begin
      r_bv = (mq.size() != 0); r_br = r_bv;
      step();
    end
    chk("rr_cnt", 32'(gq.size() >= 5), 1);
    if (gq.size() >= 5) begin
      chk("rr_g0", gq[0], 0); chk("rr_g1", gq[1], 1); chk("rr_g2", gq[2], 2);
      chk("rr_g3", gq[3], 3); chk("rr_g4", gq[4], 0);
    end

    // Late ch0 request queues behind ch2 and ch3.
    do_reset();
    r_vld = 4'b1110; r_ardy = 1;
    for (int i = 0; i < 14; i++) begin
      if (i == 1) r_vld[0] = 1'b1;
      r_bv = (mq.size() != 0); r_br = r_bv;
      step();
      if (m_pick >= 0) r_vld[m_pick] = 1'b0;
    end
    chk("late_cnt", gq.size(), 4);
    if (gq.size() == 4) begin
      chk("late_g0", gq[0], 1); chk("late_g1", gq[1], 2);
      chk("late_g2", gq[2], 3); chk("late_g3", gq[3], 0);
    end

    // Outstanding limit of 2 with no returning beats.
    do_reset();
    r_vld = '1; r_ardy = 1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (m_pick >= 0) r_vld[m_pick] = 1'b0;
    end
    chk("ostd_grants", gq.size(), 2);
    chk("ostd_full", 32'(ifc.ostd_cnt), 2);
    r_bv = 1; r_br = 1; step(); r_bv = 0; r_br = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (m_pick >= 0) r_vld[m_pick] = 1'b0;
    end
    chk("ostd_third", gq.size(), 3);

    // Push of ch1's order and retirement of ch0 in the same cycle.
    do_reset();
    r_vld = 4'b0011; r_len[0] = 8'd1; r_len[1] = 8'd0; r_ardy = 1;
    step(); r_vld[0] = 1'b0;
    step();
    r_bv = 1; r_br = 1; step();
    r_vld[1] = 1'b0; step();
    r_bv = 0; r_br = 0;
    chk("pp_ostd", 32'(ifc.ostd_cnt), 1);
    chk("pp_done", 32'(ifc.chn_done), 32'(4'b0001));
    chk("pp_busy", 32'(ifc.chn_busy), 32'(4'b0010));

    // Full-length transaction: arlen=255 retires on beat 256.
    do_reset();
    r_vld = 4'b1000; r_len[3] = 8'd255; r_ardy = 1;
    step(); r_vld = '0;
    step();
    r_bv = 1; r_br = 1;
    for (int i = 0; i < 256; i++) begin
      step();
      if (i == 254) chk("len255_early", 32'(ifc.chn_done), 0);
    end
    r_bv = 0; r_br = 0;
    chk("len255_done", 32'(ifc.chn_done), 32'(4'b1000));
    chk("len255_ostd", 32'(ifc.ostd_cnt), 0);

    // Stray beat sets a sticky error, cleared only by reset.
    do_reset();
    r_bv = 1; r_br = 1; step(); r_bv = 0; r_br = 0;
    step(); step(); step();
    chk("err_sticky", 32'(ifc.beat_err), 1);
    do_reset();
    chk("err_clr", 32'(ifc.beat_err), 0);

    // Reset with two orders outstanding.
    r_vld = 4'b0011; r_len[0] = 8'd5; r_len[1] = 8'd5; r_ardy = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (m_pick >= 0) r_vld[m_pick] = 1'b0;
    end
    chk("mid_ostd", 32'(ifc.ostd_cnt), 2);
    areset = 1; step(); areset = 0;
    chk("mid_vld", 32'(ifc.atx_vld), 0);
    chk("mid_arid", 32'(ifc.atx_arid), 0);
    chk("mid_arlen", 32'(ifc.atx_arlen), 0);
    chk("mid_busy", 32'(ifc.chn_busy), 0);
    chk("mid_ostd0", 32'(ifc.ostd_cnt), 0);
    chk("mid_rdy", 32'(ifc.chn_req_rdy), 0);
    acc = ifc.chn_done;
    for (int i = 0; i < 4; i++) begin
      step();
      acc |= ifc.chn_done;
    end
    chk("mid_no_done", 32'(acc), 0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < N; i++)
        if (!r_vld[i] && $urandom_range(0, 3) == 0) begin
          r_vld[i] = 1'b1;
          r_len[i] = ($urandom_range(0, 7) == 0) ? LW'($urandom_range(0, 40)) : LW'($urandom_range(0, 3));
        end
      r_ardy = ($urandom_range(0, 9) < 7);
      r_bv   = ($urandom_range(0, 9) < 6);
      r_br   = (mq.size() != 0) && ($urandom_range(0, 9) < 7);
      step();
      if (m_pick >= 0) r_vld[m_pick] = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
